// File: rtl/pe_mac_accumulator_if.sv
// Handshake bundle between the PE input/output buffers and the MAC accumulator.
// master = accumulator side, slave = buffer side.
interface pe_mac_accumulator_if #(
  parameter int WIDTH      = 8,
  parameter int PSUM_WIDTH = 20
);
  logic                  ifmap_valid;
  logic [WIDTH-1:0]      ifmap_data;
  logic                  ifmap_read_en;
  logic                  filter_valid;
  logic [WIDTH-1:0]      filter_data;
  logic                  filter_read_en;
  logic                  psum_ready;
  logic                  psum_write_en;
  logic [PSUM_WIDTH-1:0] psum_data;
  logic                  busy;

  modport master (
    input  ifmap_valid, ifmap_data, filter_valid, filter_data, psum_ready,
    output ifmap_read_en, filter_read_en, psum_write_en, psum_data, busy
  );

  modport slave (
    output ifmap_valid, ifmap_data, filter_valid, filter_data, psum_ready,
    input  ifmap_read_en, filter_read_en, psum_write_en, psum_data, busy
  );
endinterface

// File: rtl/pe_mac_accumulator.sv
// Signed MAC that folds FILT_LEN ifmap x filter products into one psum word.
// Optional macro PE_MAC_RELU_EN clamps negative psums to zero on the output path.
module pe_mac_accumulator #(
  parameter int WIDTH      = 8,
  parameter int PSUM_WIDTH = 20,
  parameter int FILT_LEN   = 4
) (
  input logic                    clk,
  input logic                    rst,
  pe_mac_accumulator_if.master   bus
);
  localparam int PW2   = 2 * WIDTH;
  localparam int CNT_W = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FILT_LEN - 1);

  typedef enum logic {ACCUM, EMIT} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PSUM_WIDTH-1:0] acc_q, acc_d;

  logic                  fire;
  logic signed [PW2-1:0] prod;
  logic [PSUM_WIDTH-1:0] prodExt;

  assign prod    = PW2'($signed(bus.ifmap_data)) * PW2'($signed(bus.filter_data));
  assign prodExt = PSUM_WIDTH'(prod);

  // Gating with rst keeps both buffers and the psum write quiet in the reset cycle.
  assign fire               = !rst && (state_q == ACCUM) && bus.ifmap_valid && bus.filter_valid;
  assign bus.ifmap_read_en  = fire;
  assign bus.filter_read_en = fire;
  assign bus.psum_write_en  = !rst && (state_q == EMIT) && bus.psum_ready;
  assign bus.busy           = (state_q == EMIT) || (cnt_q != '0);

`ifdef PE_MAC_RELU_EN
  assign bus.psum_data = acc_q[PSUM_WIDTH-1] ? '0 : acc_q;
`else
  assign bus.psum_data = acc_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    case (state_q)
      ACCUM: begin
        if (fire) begin
          acc_d = (cnt_q == '0) ? prodExt : acc_q + prodExt;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = EMIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      EMIT: begin
        if (bus.psum_ready) state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end
endmodule

// File: tb/tb_pe_mac_accumulator.sv
// Directed bench for pe_mac_accumulator: default instance plus a PSUM_WIDTH=16 instance for wrap-around.
// Expected values are hand-computed; PE_MAC_RELU_EN switches the signed-sum expectation.
module tb_pe_mac_accumulator;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pe_mac_accumulator_if #(.WIDTH(8), .PSUM_WIDTH(20)) bus ();
  pe_mac_accumulator_if #(.WIDTH(8), .PSUM_WIDTH(16)) busW ();

  pe_mac_accumulator #(.WIDTH(8), .PSUM_WIDTH(20), .FILT_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pe_mac_accumulator #(.WIDTH(8), .PSUM_WIDTH(16), .FILT_LEN(4)) dutW (
    .clk (clk),
    .rst (rst),
    .bus (busW)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkBit(string tag, logic observed, logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic checkWord(string tag, logic [19:0] observed, logic [19:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed 0x%05h expected 0x%05h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(logic iv, logic [7:0] id, logic fv, logic [7:0] fd, logic pr);
    bus.ifmap_valid  = iv;
    bus.ifmap_data   = id;
    bus.filter_valid = fv;
    bus.filter_data  = fd;
    bus.psum_ready   = pr;
  endtask

  // Samples the current cycle at the falling edge, then moves just past the next rising edge.
  task automatic checkOutput(string tag, logic expRd, logic expWr, logic expBusy,
                             logic chkData, logic [19:0] expData);
    @(negedge clk);
    checkBit({tag, ".ifmap_read_en"}, bus.ifmap_read_en, expRd);
    checkBit({tag, ".filter_read_en"}, bus.filter_read_en, expRd);
    checkBit({tag, ".psum_write_en"}, bus.psum_write_en, expWr);
    checkBit({tag, ".busy"}, bus.busy, expBusy);
    if (chkData) checkWord({tag, ".psum_data"}, bus.psum_data, expData);
    tick();
  endtask

  task automatic feedPair(string tag, logic [7:0] i, logic [7:0] f, logic expBusy);
    applyStimulus(1'b1, i, 1'b1, f, 1'b1);
    checkOutput(tag, 1'b1, 1'b0, expBusy, 1'b0, 20'h0);
  endtask

  task automatic emitSum(string tag, logic [19:0] expData);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    checkOutput(tag, 1'b0, 1'b1, 1'b1, 1'b1, expData);
  endtask

  task automatic feedBasic(string tag);
    feedPair({tag, ".p0"}, 8'd1, 8'd5, 1'b0);
    feedPair({tag, ".p1"}, 8'd2, 8'd6, 1'b1);
    feedPair({tag, ".p2"}, 8'd3, 8'd7, 1'b1);
    feedPair({tag, ".p3"}, 8'd4, 8'd8, 1'b1);
  endtask

  initial begin
    logic [19:0] signedExp;
`ifdef PE_MAC_RELU_EN
    signedExp = 20'h00000;
`else
    signedExp = 20'hFFFE8;
`endif
    busW.ifmap_valid  = 1'b0;
    busW.ifmap_data   = 8'h00;
    busW.filter_valid = 1'b0;
    busW.filter_data  = 8'h00;
    busW.psum_ready   = 1'b1;

    // Reset values while rst is held, then idle after release.
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    tick();
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b1, 20'h0);
    rst = 1'b0;
    checkOutput("idle", 1'b0, 1'b0, 1'b0, 1'b1, 20'h0);

    // Basic sum: 1*5+2*6+3*7+4*8 = 70.
    feedBasic("basic");
    emitSum("basic.emit", 20'd70);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    checkOutput("basic.after", 1'b0, 1'b0, 1'b0, 1'b0, 20'h0);

    // Signed: (-3)*2 four times = -24.
    feedPair("signed.p0", 8'hFD, 8'h02, 1'b0);
    feedPair("signed.p1", 8'hFD, 8'h02, 1'b1);
    feedPair("signed.p2", 8'hFD, 8'h02, 1'b1);
    feedPair("signed.p3", 8'hFD, 8'h02, 1'b1);
    emitSum("signed.emit", signedExp);

    // Input bubble: filter side empty for three cycles after the second pair.
    feedPair("bubble.p0", 8'd1, 8'd5, 1'b0);
    feedPair("bubble.p1", 8'd2, 8'd6, 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'd3, 1'b0, 8'd7, 1'b1);
      checkOutput("bubble.gap", 1'b0, 1'b0, 1'b1, 1'b0, 20'h0);
    end
    feedPair("bubble.p2", 8'd3, 8'd7, 1'b1);
    feedPair("bubble.p3", 8'd4, 8'd8, 1'b1);
    emitSum("bubble.emit", 20'd70);

    // Output stall: five cycles of psum_ready low with valid pairs waiting.
    feedBasic("stall");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 8'd2, 1'b1, 8'd3, 1'b0);
      checkOutput("stall.hold", 1'b0, 1'b0, 1'b1, 1'b1, 20'd70);
    end
    applyStimulus(1'b1, 8'd2, 1'b1, 8'd3, 1'b1);
    checkOutput("stall.release", 1'b0, 1'b1, 1'b1, 1'b1, 20'd70);
    feedPair("stall.next0", 8'd2, 8'd3, 1'b0);
    feedPair("stall.next1", 8'd1, 8'd1, 1'b1);

    // Reset mid-operation after two pairs; the next set must carry no stale sum.
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    rst = 1'b0;
    checkOutput("midreset", 1'b0, 1'b0, 1'b0, 1'b1, 20'h0);
    feedBasic("postreset");
    emitSum("postreset.emit", 20'd70);

    // Wrap-around on the 16-bit instance: 4 * 16384 = 65536 -> 0.
    for (int k = 0; k < 4; k++) begin
      busW.ifmap_valid  = 1'b1;
      busW.ifmap_data   = 8'h80;
      busW.filter_valid = 1'b1;
      busW.filter_data  = 8'h80;
      @(negedge clk);
      checkBit("wrap.read_en", busW.ifmap_read_en, 1'b1);
      tick();
    end
    busW.ifmap_valid  = 1'b0;
    busW.filter_valid = 1'b0;
    @(negedge clk);
    checkBit("wrap.psum_write_en", busW.psum_write_en, 1'b1);
    checkWord("wrap.psum_data", {4'h0, busW.psum_data}, 20'h00000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
